// File: rtl/stack_up_mgr_arbiter_if.sv
// Upstream stack-bus bundle: NUM_CH per-manager input ports, one system output port,
// per-channel enables and sticky protocol-error flags.
interface stack_up_mgr_arbiter_if #(
   parameter int NUM_CH = 4,
   parameter int CNTL_W = 2,
   parameter int TYPE_W = 2,
   parameter int DATA_W = 64,
   parameter int OOB_W  = 32
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH-1:0]        cfg__chan_enable;
   logic [NUM_CH-1:0]        pe__stu__valid;
   logic [NUM_CH*CNTL_W-1:0] pe__stu__cntl;
   logic [NUM_CH*TYPE_W-1:0] pe__stu__type;
   logic [NUM_CH*DATA_W-1:0] pe__stu__data;
   logic [NUM_CH*OOB_W-1:0]  pe__stu__oob_data;
   logic [NUM_CH-1:0]        stu__pe__ready;
   logic                     stu__sys__valid;
   logic [CNTL_W-1:0]        stu__sys__cntl;
   logic [TYPE_W-1:0]        stu__sys__type;
   logic [DATA_W-1:0]        stu__sys__data;
   logic [OOB_W-1:0]         stu__sys__oob_data;
   logic [CH_W-1:0]          stu__sys__chan_id;
   logic                     sys__stu__ready;
   logic [NUM_CH-1:0]        stu__sys__proto_err;

   modport master (
      output cfg__chan_enable, pe__stu__valid, pe__stu__cntl, pe__stu__type,
             pe__stu__data, pe__stu__oob_data, sys__stu__ready,
      input  stu__pe__ready, stu__sys__valid, stu__sys__cntl, stu__sys__type,
             stu__sys__data, stu__sys__oob_data, stu__sys__chan_id, stu__sys__proto_err
   );

   modport slave (
      input  cfg__chan_enable, pe__stu__valid, pe__stu__cntl, pe__stu__type,
             pe__stu__data, pe__stu__oob_data, sys__stu__ready,
      output stu__pe__ready, stu__sys__valid, stu__sys__cntl, stu__sys__type,
             stu__sys__data, stu__sys__oob_data, stu__sys__chan_id, stu__sys__proto_err
   );
endinterface

// File: rtl/stack_up_mgr_arbiter.sv
// Upstream concentrator: per-channel FIFOs feeding one output register through a
// packet-locked round-robin arbiter, with per-channel SOM/EOM protocol tracking.
module stack_up_mgr_arbiter #(
   parameter int NUM_CH     = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int CNTL_W     = 2,
   parameter int TYPE_W     = 2,
   parameter int DATA_W     = 64,
   parameter int OOB_W      = 32
) (
   input logic                   clk,
   input logic                   reset_poweron,
   stack_up_mgr_arbiter_if.slave bus
);
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int AW     = $clog2(FIFO_DEPTH);
   localparam int CW     = AW + 1;
   localparam int BEAT_W = CNTL_W + TYPE_W + DATA_W + OOB_W;

   typedef enum logic {IDLE, PKT} state_t;

   function automatic logic is_som(input logic [CNTL_W-1:0] cntl);
      return cntl[0];
   endfunction

   function automatic logic is_last(input logic [CNTL_W-1:0] cntl);
      return cntl[1];
   endfunction

   function automatic logic proto_bad(input logic [CNTL_W-1:0] cntl, input logic in_pkt);
      return is_som(cntl) ? in_pkt : !in_pkt;
   endfunction

   function automatic logic next_in_pkt(input logic [CNTL_W-1:0] cntl, input logic in_pkt);
      if (is_som(cntl)) return !is_last(cntl);
      if (is_last(cntl)) return 1'b0;
      return in_pkt;
   endfunction

   logic [BEAT_W-1:0] mem [NUM_CH][FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr [NUM_CH];
   logic [AW-1:0]     rd_ptr [NUM_CH];
   logic [CW-1:0]     count [NUM_CH];
   logic [CW-1:0]     count_next [NUM_CH];
   logic [BEAT_W-1:0] in_beat [NUM_CH];

   logic [NUM_CH-1:0] ready, in_pkt, proto_err, push, pop, empty;
   state_t            state;
   logic [CH_W-1:0]   grant, last_grant, sel, cand;
   logic              sel_found, can_load, pop_any;
   logic [BEAT_W-1:0] head;

   logic              vld_p1;
   logic [BEAT_W-1:0] beat_p1;
   logic [CH_W-1:0]   chan_p1;

   assign push     = bus.pe__stu__valid & ready;
   assign can_load = !vld_p1 || bus.sys__stu__ready;

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         in_beat[i]    = {bus.pe__stu__cntl[i*CNTL_W +: CNTL_W],
                          bus.pe__stu__type[i*TYPE_W +: TYPE_W],
                          bus.pe__stu__data[i*DATA_W +: DATA_W],
                          bus.pe__stu__oob_data[i*OOB_W +: OOB_W]};
         empty[i]      = (count[i] == '0);
         count_next[i] = count[i] + CW'(push[i]) - CW'(pop[i]);
      end
   end

   // Arbitration: search from last_grant+1 in IDLE, stay locked on grant in PKT.
   always_comb begin
      sel       = grant;
      sel_found = 1'b0;
      cand      = '0;
      pop       = '0;
      if (state == IDLE) begin
         for (int k = 1; k <= NUM_CH; k++) begin
            cand = CH_W'((int'(last_grant) + k) % NUM_CH);
            if (!sel_found && !empty[cand] && bus.cfg__chan_enable[cand]) begin
               sel       = cand;
               sel_found = 1'b1;
            end
         end
         if (sel_found && can_load) pop[sel] = 1'b1;
      end else if (!empty[grant] && can_load) begin
         pop[grant] = 1'b1;
      end
      pop_any = |pop;
      head    = mem[sel][rd_ptr[sel]];
   end

   // Stage p0: input FIFOs, registered ready and protocol tracking
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++)
         if (push[i]) mem[i][wr_ptr[i]] <= in_beat[i];
   end

   always_ff @(posedge clk or posedge reset_poweron) begin
      if (reset_poweron) begin
         for (int i = 0; i < NUM_CH; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            count[i]  <= '0;
         end
         ready     <= '0;
         in_pkt    <= '0;
         proto_err <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
            if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
            count[i] <= count_next[i];
            ready[i] <= (count_next[i] < CW'(FIFO_DEPTH));
            if (push[i]) begin
               in_pkt[i] <= next_in_pkt(in_beat[i][BEAT_W-1 -: CNTL_W], in_pkt[i]);
               if (proto_bad(in_beat[i][BEAT_W-1 -: CNTL_W], in_pkt[i]))
                  proto_err[i] <= 1'b1;
            end
         end
      end
   end

   // Stage p1: arbiter FSM and output register
   always_ff @(posedge clk or posedge reset_poweron) begin
      if (reset_poweron) begin
         state      <= IDLE;
         grant      <= '0;
         last_grant <= CH_W'(NUM_CH - 1);
         vld_p1     <= 1'b0;
         beat_p1    <= '0;
         chan_p1    <= '0;
      end else begin
         if (pop_any) begin
            vld_p1  <= 1'b1;
            beat_p1 <= head;
            chan_p1 <= sel;
         end else if (bus.sys__stu__ready) begin
            vld_p1 <= 1'b0;
         end
         case (state)
            IDLE: if (pop_any) begin
               grant      <= sel;
               last_grant <= sel;
               if (!is_last(head[BEAT_W-1 -: CNTL_W])) state <= PKT;
            end
            PKT: if (pop_any && is_last(head[BEAT_W-1 -: CNTL_W])) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.stu__pe__ready      = ready;
   assign bus.stu__sys__valid     = vld_p1;
   assign bus.stu__sys__cntl      = beat_p1[BEAT_W-1 -: CNTL_W];
   assign bus.stu__sys__type      = beat_p1[DATA_W+OOB_W +: TYPE_W];
   assign bus.stu__sys__data      = beat_p1[OOB_W +: DATA_W];
   assign bus.stu__sys__oob_data  = beat_p1[OOB_W-1:0];
   assign bus.stu__sys__chan_id   = chan_p1;
   assign bus.stu__sys__proto_err = proto_err;
endmodule
